fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised successor of the pipeline's forwarding logic; owns both forwarding and hazard detection.
- Internally tracks in-flight register writes (dest, regwrite, is_load) for DEPTH post-EX stages, so stage dest/regwrite no longer need per-stage wiring.
- Generates EX-operand and decode-stage (branch compare) forward selects, the load-use/branch stall, a saturating stall counter and a sticky hazard-error flag.
- Sits beside the pipeline registers in the core.

Parameters:
REG_AW, 5, register address width (register 0 hard-wired zero)
NUM_SRC, 2, source operands per instruction
DEPTH, 2, tracked post-EX stages (1=M, 2=W, >2 = extra writeback buffers)
LD_READY, 2, lowest tracked stage index whose load result is forwardable
CNT_W, 16, stall counter width
SEL_W, clog2(DEPTH+1), forward select width (derived, not overridable)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-low reset
hold  in  1  whole pipeline frozen this cycle
flush_e  in  1  kill the instruction currently in EX
e_valid  in  1  EX holds a real instruction
e_regwrite  in  1  EX instruction writes a register
e_is_load  in  1  EX instruction is a load
e_dest  in  REG_AW  EX destination register
e_src  in  NUM_SRC*REG_AW  EX source registers, source i at [i*REG_AW +: REG_AW]
d_valid  in  1  decode holds a real instruction
d_is_branch  in  1  decode instruction compares operands in D
d_src  in  NUM_SRC*REG_AW  decode source registers
fwd_sel_e  out  NUM_SRC*SEL_W  per-source EX mux select: 0 = register file, k = tracked stage k
fwd_sel_d  out  NUM_SRC*SEL_W  per-source decode mux select, same encoding
stall_d  out  1  freeze F/D and insert a bubble into EX
stall_cnt  out  CNT_W  saturating count of stall cycles
hazard_err  out  1  sticky: EX consumed a not-yet-ready load result

Behaviour:
- State: entry p[1..DEPTH], each holding {valid, regwrite, is_load, dest}.
- Reset (async, reset=0): all entries invalid, stall_cnt=0, hazard_err=0. stall_d is forced 0 while reset=0. fwd_sel_e/fwd_sel_d are therefore 0.
- Advance (posedge, hold=0):
  - p[1] <= {e_valid & ~flush_e, e_regwrite, e_is_load, e_dest}.
  - p[k+1] <= p[k]; p[DEPTH] is discarded.
- hold=1: no entry, counter or flag changes. hold dominates flush_e.
- Live entry: valid & regwrite & dest != 0. Register 0 never matches.
- fwd_sel_e[i], combinational:
  - Smallest k with live p[k] and p[k].dest == e_src[i]; 0 if none.
  - Latency 0, from state and inputs.
  - Youngest match wins; duplicate dests in older stages are ignored.
- fwd_sel_d[i]: same rule against d_src[i]. Meaningful only when d_is_branch=1; computed regardless.
- stall_d, combinational, with d_valid=1 and reset=1. For each source i with d_src[i] != 0, find the youngest producer among {EX instruction (valid, regwrite, not flushed), p[1..DEPTH]}. EX counts as stage 0.
  - Non-branch: stall if the producer is a load at stage s with s+1 < LD_READY.
  - Branch: stall if the producer is in EX, or is a load at stage s < LD_READY.
  - Only the youngest producer is considered; an older ready copy does not cancel the stall.
- A stall does not affect the advance: the EX entry still shifts into p[1]. The external pipeline delivers the bubble as e_valid=0 on the next cycle.
- stall_cnt increments on each posedge with stall_d=1 and hold=0. It saturates at 2^CNT_W-1 and never wraps.
- hazard_err sets on a posedge with hold=0 and e_valid=1, when for some source the youngest live match is a load at stage k < LD_READY. It clears only by reset.
- Reset mid-operation discards all in-flight entries. The first cycle after reset release forwards nothing.

Decomposition:
- Package fwd_hazard_pkg: default widths, the entry typedef {valid, regwrite, is_load, dest}, and the select encoding constant SEL_RF=0.
- One sub-module, fwd_match_select: priority youngest-match encoder over DEPTH entries for one source register. It outputs the select, a hit flag, and the matched entry's is_load and stage. Instantiated 2*NUM_SRC times (EX and D).
- Stall/counter/flag logic stays in the top.

Test Plan:
- DEPTH=2, LD_READY=2. Cycle0: EX add r5. Cycle1: EX src0=r5 -> fwd_sel_e[0]=1. Cycle2: EX src1=r5 -> fwd_sel_e[1]=2. Cycle3 -> 0.
- p[1].dest=r3 and p[2].dest=r3 both live, EX src0=r3 -> sel=1. EX writes r0, next consumer src r0 -> sel=0.
- Load-use:
  - EX lw r7, D src0=r7 -> stall_d=1, stall_cnt 0->1.
  - Next cycle: EX bubble, p[1]=lw r7, D src r7 -> stall_d=0.
  - Following cycle: EX src r7 -> fwd_sel_e=2, hazard_err=0.
- Branch: D beq src0=r4, EX add r4 -> stall_d=1. Next cycle p[1]=add r4 -> stall_d=0, fwd_sel_d[0]=1.
- hold=1 for 3 cycles with a pending stall -> entries unchanged, stall_cnt unchanged. flush_e=1 on add r9 -> later consumer of r9 gets sel=0.
- Error and reset:
  - Force EX src=r7 while p[1]=lw r7 -> hazard_err=1 and it stays set.
  - Pull reset low mid-stream -> hazard_err=0, stall_cnt=0, all sels 0 next cycle.
  - With CNT_W=2, 5 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/fwd_hazard_pkg.sv
// Shared widths, the in-flight write entry and the forward-select encoding
// used by the forwarding / hazard unit.
package fwd_hazard_pkg;

    localparam int DEF_REG_AW   = 5;
    localparam int DEF_NUM_SRC  = 2;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_LD_READY = 2;
    localparam int DEF_CNT_W    = 16;

    // Entries store register addresses at a fixed width so one struct type
    // serves every REG_AW up to this bound; narrower addresses are zero-extended.
    localparam int MAX_REG_AW = 8;

    localparam int SEL_RF = 0;

    typedef logic [MAX_REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        logic      regwrite;
        logic      is_load;
        reg_addr_t dest;
    } entry_t;

endpackage

// File: rtl/fwd_match_select.sv
// Youngest-match priority encoder: finds the smallest tracked stage whose live
// write targets the given source register.
module fwd_match_select
    import fwd_hazard_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int SEL_W = $clog2(DEF_DEPTH + 1)
) (
    input  entry_t [DEPTH:1]   entries,
    input  reg_addr_t          src,
    output logic [SEL_W-1:0]   sel,
    output logic               hit,
    output logic               is_load,
    output logic [SEL_W-1:0]   stage
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel     = SEL_W'(SEL_RF);
        hit     = 1'b0;
        is_load = 1'b0;
        stage   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (entries[k].valid && entries[k].regwrite &&
                entries[k].dest != '0 && entries[k].dest == src) begin
                sel     = SEL_W'(k);
                hit     = 1'b1;
                is_load = entries[k].is_load;
                stage   = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard detection: tracks in-flight writes past EX and derives
// operand forward selects, the load-use/branch stall, a stall counter and an error flag.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LD_READY = DEF_LD_READY,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       hold,
    input  logic                                       flush_e,
    input  logic                                       e_valid,
    input  logic                                       e_regwrite,
    input  logic                                       e_is_load,
    input  logic [REG_AW-1:0]                          e_dest,
    input  logic [NUM_SRC*REG_AW-1:0]                  e_src,
    input  logic                                       d_valid,
    input  logic                                       d_is_branch,
    input  logic [NUM_SRC*REG_AW-1:0]                  d_src,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]         fwd_sel_e,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]         fwd_sel_d,
    output logic                                       stall_d,
    output logic [CNT_W-1:0]                           stall_cnt,
    output logic                                       hazard_err
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    entry_t [DEPTH:1] p;
    entry_t           e_ent;

    reg_addr_t        e_addr  [NUM_SRC];
    reg_addr_t        d_addr  [NUM_SRC];
    logic             e_hit   [NUM_SRC];
    logic             e_load  [NUM_SRC];
    logic [SEL_W-1:0] e_stage [NUM_SRC];
    logic             d_hit   [NUM_SRC];
    logic             d_load  [NUM_SRC];
    logic [SEL_W-1:0] d_stage [NUM_SRC];

    logic stall_any;
    logic err_now;

    assign e_ent = '{valid:    e_valid & ~flush_e,
                     regwrite: e_regwrite,
                     is_load:  e_is_load,
                     dest:     reg_addr_t'(e_dest)};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign e_addr[i] = reg_addr_t'(e_src[i*REG_AW +: REG_AW]);
        assign d_addr[i] = reg_addr_t'(d_src[i*REG_AW +: REG_AW]);

        fwd_match_select #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_e (
            .entries (p),
            .src     (e_addr[i]),
            .sel     (fwd_sel_e[i*SEL_W +: SEL_W]),
            .hit     (e_hit[i]),
            .is_load (e_load[i]),
            .stage   (e_stage[i])
        );

        fwd_match_select #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_d (
            .entries (p),
            .src     (d_addr[i]),
            .sel     (fwd_sel_d[i*SEL_W +: SEL_W]),
            .hit     (d_hit[i]),
            .is_load (d_load[i]),
            .stage   (d_stage[i])
        );
    end

    // The EX instruction is stage 0 and shadows every tracked stage; only the
    // youngest producer decides whether decode must wait.
    always_comb begin
        stall_any = 1'b0;
        err_now   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (d_addr[i] != '0) begin
                if (e_ent.valid && e_ent.regwrite && e_ent.dest == d_addr[i]) begin
                    if (d_is_branch || (e_ent.is_load && 1 < LD_READY))
                        stall_any = 1'b1;
                end else if (d_hit[i] && d_load[i]) begin
                    if (d_is_branch ? (int'(d_stage[i]) < LD_READY)
                                    : (int'(d_stage[i]) + 1 < LD_READY))
                        stall_any = 1'b1;
                end
            end
            if (e_hit[i] && e_load[i] && int'(e_stage[i]) < LD_READY)
                err_now = 1'b1;
        end
    end

    assign stall_d = reset & d_valid & stall_any;

    // A stall does not hold EX back: its write still enters p[1]; the bubble
    // arrives from the pipeline as e_valid=0 on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p          <= '0;
            stall_cnt  <= '0;
            hazard_err <= 1'b0;
        end else if (!hold) begin
            p[1] <= e_ent;
            for (int k = 2; k <= DEPTH; k++)
                p[k] <= p[k-1];
            if (stall_d && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (e_valid && err_now)
                hazard_err <= 1'b1;
        end
    end

endmodule
